// File: rtl/fan_row_accumulator.sv
// Terminal fan stage: sums occupied fan lines into a per-row accumulator bank,
// then drains touched rows in ascending order on a flush request.
module fan_row_accumulator #(
  parameter int N_STACK = 4,
  parameter int DW_DATA = 32,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int NUM_IN  = 6,
  parameter int DW_LINE = N_STACK*DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN*DW_LINE-1:0]  in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW_ROW-1:0]          out_row,
  output logic [N_STACK*DW_DATA-1:0] out_data,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);
  localparam int DEPTH   = 1 << DW_ROW;
  localparam int LANES_W = N_STACK*DW_DATA;

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_DONE} state_t;

  state_t               state, state_nxt;
  logic [LANES_W-1:0]   acc     [DEPTH];
  logic [LANES_W-1:0]   acc_sum [DEPTH];
  logic [DEPTH-1:0]     hit, hit_new, sel_onehot;
  logic [NUM_IN-1:0]    occ;
  logic [DW_ROW-1:0]    line_row [NUM_IN];
  logic [NUM_IN*(DW_CTRL-2)-1:0] unused_ctrl_lo;
  logic [DW_ROW-1:0]    sel_row;
  logic                 sel_last;

  // Only the two top ctrl bits mark a line as carrying data.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_line
    assign occ[i]      = in[i*DW_LINE + DW_LINE-1] | in[i*DW_LINE + DW_LINE-2];
    assign line_row[i] = in[i*DW_LINE + LANES_W +: DW_ROW];
    assign unused_ctrl_lo[i*(DW_CTRL-2) +: (DW_CTRL-2)] =
      in[i*DW_LINE + LANES_W + DW_ROW +: (DW_CTRL-2)];
  end

  always_comb begin
    hit_new = '0;
    for (int r = 0; r < DEPTH; r++) begin
      acc_sum[r] = acc[r];
      for (int i = 0; i < NUM_IN; i++) begin
        if (occ[i] && line_row[i] == DW_ROW'(r)) begin
          hit_new[r] = 1'b1;
          for (int l = 0; l < N_STACK; l++) begin
            acc_sum[r][l*DW_DATA +: DW_DATA] = acc_sum[r][l*DW_DATA +: DW_DATA]
                                             + in[i*DW_LINE + l*DW_DATA +: DW_DATA];
          end
        end
      end
    end
  end

  // Lowest set hit bit is the row presented during drain.
  always_comb begin
    sel_row    = '0;
    sel_onehot = '0;
    for (int r = DEPTH-1; r >= 0; r--) begin
      if (hit[r]) sel_row = DW_ROW'(r);
    end
    sel_onehot[sel_row] = 1'b1;
    sel_last = (hit & ~sel_onehot) == '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (flush) state_nxt = (|(hit | hit_new)) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (out_ready && sel_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  // Stream: a word transfers on out_valid & out_ready; while stalled the word
  // is held unchanged, and out_valid only falls after a transfer.
  assign busy      = (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign out_valid = busy;
  assign out_row   = busy ? sel_row : '0;
  assign out_data  = busy ? acc[sel_row] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACCUM;
      hit     <= '0;
      overrun <= 1'b0;
      for (int r = 0; r < DEPTH; r++) acc[r] <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ACCUM) begin
        hit <= hit | hit_new;
        for (int r = 0; r < DEPTH; r++) acc[r] <= acc_sum[r];
      end else if (state == ST_DRAIN && out_ready) begin
        acc[sel_row] <= '0;
        hit[sel_row] <= 1'b0;
      end
      if (state != ST_ACCUM && |occ) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fan_row_accumulator.sv
// Bench for fan_row_accumulator: directed scenarios plus randomized tiles
// compared against a row-bank model and an expected drain queue.
module tb_fan_row_accumulator;
  localparam int LW = 4*32 + 4 + 4;
  localparam int WW = 4 + 128;

  logic                clk = 1'b0;
  logic                rst;
  logic [6*LW-1:0]     in_bus;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_row;
  logic [127:0]        out_data;
  logic                busy;
  logic                done;
  logic                overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   m_acc [16][4];
  bit            m_hit [16];
  logic [WW-1:0] exp_q [$];
  bit            ready_pat [$];
  logic [WW-1:0] first_word;
  bit            got_first;

  fan_row_accumulator dut (
    .clk(clk), .rst(rst), .in(in_bus), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_line(input int i, input logic [3:0] ctrl, input logic [3:0] row,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    in_bus[i*LW +: LW] = {ctrl, row, d3, d2, d1, d0};
  endtask

  task automatic randomize_lines();
    logic [31:0] d [4];
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < 4; l++)
        d[l] = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      set_line(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d[0], d[1], d[2], d[3]);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      m_hit[r] = 0;
      for (int l = 0; l < 4; l++) m_acc[r][l] = '0;
    end
  endtask

  // A line counts when either top ctrl bit is set; lanes add independently mod 2^32.
  task automatic model_accept();
    logic [LW-1:0] ln;
    logic [3:0]    r;
    for (int i = 0; i < 6; i++) begin
      ln = in_bus[i*LW +: LW];
      if (ln[LW-1] || ln[LW-2]) begin
        r = ln[131:128];
        m_hit[r] = 1;
        for (int l = 0; l < 4; l++) m_acc[r][l] = m_acc[r][l] + ln[l*32 +: 32];
      end
    end
  endtask

  task automatic build_exp();
    logic [3:0] rr;
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      rr = 4'(r);
      if (m_hit[r]) exp_q.push_back({rr, m_acc[r][3], m_acc[r][2], m_acc[r][1], m_acc[r][0]});
    end
    model_clear();
  endtask

  // ready_mode: 0 always ready, 1 random, 2 from ready_pat. inject drives occupied lines during drain.
  task automatic run_flush(input int ready_mode, input bit inject);
    int nwords;
    bit fin, stalled, r;
    logic [WW-1:0] prev_word;
    model_accept();
    build_exp();
    nwords = exp_q.size();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_bus = '0;
    fin = 0; stalled = 0; got_first = 0; prev_word = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (inject) begin randomize_lines(); in_bus[LW-1] = 1'b1; end
      n_checks++;
      if (busy !== out_valid) begin
        n_errors++; $display("FAIL busy_vs_valid: busy=%b out_valid=%b", busy, out_valid);
      end
      if (done === 1'b1) begin
        fin = 1;
        n_checks++;
        if ({out_valid, out_row, out_data} !== '0) begin
          n_errors++; $display("FAIL done_outputs: valid=%b row=%0d data=%h, need 0", out_valid, out_row, out_data);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
          n_errors++; $display("FAIL missing_words: %0d words never drained, need 0", exp_q.size());
        end
        if (ready_mode == 0) begin
          n_checks++;
          if (cyc != nwords) begin
            n_errors++; $display("FAIL done_latency: done at cycle %0d, need %0d", cyc, nwords);
          end
        end
      end else if (out_valid === 1'b1) begin
        if (!got_first) begin first_word = {out_row, out_data}; got_first = 1; end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL extra_word: row=%0d data=%h, need no word", out_row, out_data);
        end else if ({out_row, out_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL drain_word: got %h, need %h", {out_row, out_data}, exp_q[0]);
        end
        if (stalled) begin
          n_checks++;
          if ({out_row, out_data} !== prev_word) begin
            n_errors++; $display("FAIL stall_hold: got %h, need %h", {out_row, out_data}, prev_word);
          end
        end
        case (ready_mode)
          0:       r = 1;
          1:       r = 1'($urandom_range(0, 1));
          default: r = (ready_pat.size() != 0) ? ready_pat.pop_front() : 1'b1;
        endcase
        out_ready = r;
        stalled = !r;
        prev_word = {out_row, out_data};
        tick();
        if (r && exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        n_checks++; n_errors++;
        $display("FAIL drain_idle: out_valid=%b done=%b in drain, need one of them", out_valid, done);
        tick();
      end
    end
    if (!fin) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: done=0 after 300 cycles, need 1");
    end
    out_ready = 1'b0;
    in_bus = '0;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL after_done: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({out_valid, busy, done, overrun, out_row, out_data} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h, need 0", {out_valid, busy, done, overrun, out_row, out_data});
    end
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({out_valid, busy, done, overrun, out_row, out_data} !== '0) begin
        n_errors++; $display("FAIL idle_outputs: cycle %0d got %h, need 0", c, {out_valid, busy, done, overrun, out_row, out_data});
      end
    end
    run_flush(0, 0);
  endtask

  task automatic test_example();
    set_line(0, 4'b1000, 4'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    set_line(5, 4'b0111, 4'd3, 32'd10, 32'd20, 32'd30, 32'd40);
    set_line(2, 4'b0000, 4'd3, 32'd99, 32'd99, 32'd99, 32'd99);
    model_accept();
    tick();
    in_bus = '0;
    run_flush(0, 0);
    n_checks++;
    if (!got_first || first_word !== {4'd3, 32'd44, 32'd33, 32'd22, 32'd11}) begin
      n_errors++; $display("FAIL example_word: got %h, need row 3 {44,33,22,11}", first_word);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) set_line(i, 4'b1100, 4'd7, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0);
    run_flush(0, 0);
    n_checks++;
    if (!got_first || first_word !== {4'd7, 96'd0, 32'hFFFFFFFA}) begin
      n_errors++; $display("FAIL wrap_word: got %h, need row 7 lane0 fffffffa", first_word);
    end
  endtask

  task automatic test_order_stall();
    set_line(0, 4'b1000, 4'd9,  32'd9,  32'd90,  32'd900,  32'd9000);
    set_line(1, 4'b0100, 4'd2,  32'd2,  32'd20,  32'd200,  32'd2000);
    set_line(2, 4'b1100, 4'd15, 32'd15, 32'd150, 32'd1500, 32'd15000);
    model_accept();
    tick();
    in_bus = '0;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_flush(2, 0);
    n_checks++;
    if (!got_first || first_word[131:128] !== 4'd2) begin
      n_errors++; $display("FAIL order_first_row: got %0d, need 2", first_word[131:128]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < int'($urandom_range(2, 12)); c++) begin
        randomize_lines();
        model_accept();
        tick();
      end
      randomize_lines();
      run_flush((t == 0) ? 0 : 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) set_line(i, 4'b1000, 4'(2*i + 1), $urandom, $urandom, $urandom, $urandom);
    model_accept();
    tick();
    in_bus = '0;
    run_flush(0, 0);
  endtask

  task automatic test_overrun();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_errors++; $display("FAIL overrun_pre: got %b, need 0", overrun);
    end
    set_line(0, 4'b1000, 4'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    set_line(3, 4'b0100, 4'd11, 32'd1, 32'd1, 32'd1, 32'd1);
    model_accept();
    tick();
    in_bus = '0;
    run_flush(1, 1);
    repeat (3) tick();
    n_checks++;
    if (overrun !== 1'b1) begin
      n_errors++; $display("FAIL overrun_sticky: got %b, need 1", overrun);
    end
    set_line(1, 4'b1000, 4'd6, 32'd60, 32'd61, 32'd62, 32'd63);
    model_accept();
    tick();
    in_bus = '0;
    run_flush(0, 0);
    n_checks++;
    if (!got_first || first_word !== {4'd6, 32'd63, 32'd62, 32'd61, 32'd60}) begin
      n_errors++; $display("FAIL post_done_drain: got %h, need only row 6", first_word);
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_errors++; $display("FAIL overrun_hold: got %b, need 1", overrun);
    end
  endtask

  task automatic test_rst_mid_drain();
    set_line(0, 4'b1000, 4'd1, 32'd1, 32'd1, 32'd1, 32'd1);
    set_line(1, 4'b1000, 4'd5, 32'd5, 32'd5, 32'd5, 32'd5);
    tick();
    in_bus = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_row !== 4'd1) begin
      n_errors++; $display("FAIL rst_pre_drain: valid=%b busy=%b row=%0d, need 1 1 1", out_valid, busy, out_row);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    n_checks++;
    if ({out_valid, busy, done, overrun} !== 4'b0000) begin
      n_errors++; $display("FAIL rst_abort: valid/busy/done/overrun=%b, need 0000", {out_valid, busy, done, overrun});
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_empty_flush: done=%b valid=%b, need 1 0", done, out_valid);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_after_done: done=%b valid=%b, need 0 0", done, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_bus = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_example();
    test_wrap();
    test_order_stall();
    test_random();
    test_back_to_back();
    test_overrun();
    test_rst_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fan_row_accumulator.md
# fan_row_accumulator

Terminal stage after the last fan adder level of the unstructured sparse datapath. Each cycle it samples all NUM_IN fan lines, adds every occupied line's N_STACK-lane data into a per-row accumulator bank indexed by the line's row field, and tracks which rows were touched. On a flush request it drains touched rows in ascending row order over a valid/ready stream, then pulses done.

## Interface
- N_STACK, 4, lanes per line
- DW_DATA, 32, bits per lane
- DW_ROW, 4, row-field width; bank depth 2^DW_ROW
- DW_CTRL, 4, control-field width
- NUM_IN, 6, fan lines consumed per cycle
- DW_LINE, N_STACK*DW_DATA+DW_ROW+DW_CTRL, line width; layout {ctrl, row, data}, data in LSBs
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in  in  NUM_IN*DW_LINE  fan lines; line i at [i*DW_LINE +: DW_LINE]
- flush  in  1  end-of-tile request, sampled in ACCUM only
- out_valid  out  1  drain word valid
- out_ready  in  1  downstream accepts drain word
- out_row  out  DW_ROW  row index of drain word
- out_data  out  N_STACK*DW_DATA  accumulated row sum
- busy  out  1  high while in DRAIN
- done  out  1  one-cycle pulse after last drain transfer
- overrun  out  1  sticky: occupied line arrived while not in ACCUM

## Operation
- Line occupied iff ctrl[DW_CTRL-1] | ctrl[DW_CTRL-2]; ctrl[1:0] ignored. Unoccupied lines contribute nothing regardless of row/data.
- Arithmetic: per-lane add, modulo 2^DW_DATA, no carry between lanes, no saturation.
- ACCUM: for every row r, acc[r] <= acc[r] + sum of data of all occupied lines with row==r; hit[r] set if any such line. Any number of lines (0..NUM_IN) may target the same row in one cycle; all are summed.
- flush=1 in ACCUM: that cycle's lines are still accumulated; next state DRAIN if any hit bit (including this cycle's) set, otherwise DONE.
- DRAIN: out_valid=1, out_row=lowest set hit index, out_data=acc[out_row]. On out_valid&out_ready: acc[out_row]<=0, hit[out_row]<=0; if it was the last set bit go DONE, else next lowest row presented next cycle.
- DONE: done=1 for one cycle, then ACCUM.
- In DRAIN and DONE: occupied input lines are dropped (bank unchanged), overrun<=1; flush ignored.
- overrun cleared only by rst.

## Timing
- Reset values: acc all 0, hit all 0, state ACCUM, out_valid 0, out_row 0, out_data 0, busy 0, done 0, overrun 0.
- rst mid-DRAIN aborts drain; all state cleared next cycle, pending rows lost.
- Accumulate latency: line at edge t is in acc after edge t.
- flush at edge t -> busy=out_valid=1 in cycle t+1 (hit nonempty) or done=1 in cycle t+1 (empty).
- out_valid never drops without a transfer; out_row/out_data stable while out_valid & !out_ready.
- Back-to-back: with out_ready held high, one row per cycle; K hit rows -> K transfer cycles, done in cycle after last transfer.
- out_row/out_data are 0 when out_valid=0.
- busy = (state==DRAIN); done not asserted together with out_valid.

## Test plan
- Reset then idle 10 cycles with all lines ctrl=0 -> all outputs 0, flush -> done=1 next cycle, no out_valid.
- Cycle 0: line0 {1000,row 3,lanes 1,2,3,4}, line5 {0111,row 3,lanes 10,20,30,40}; line2 ctrl 0000 row 3 lanes 99; flush in cycle 1 -> one word row 3 data {11,22,33,44}, then done.
- All 6 lines row 7 lane0 0xFFFFFFFF each, flush -> row 7 lane0 0xFFFFFFFA, other lanes 0 (wrap, no lane carry).
- Rows 9, 2, 15 hit, flush with out_ready toggling 1,0,0,1,1 -> rows 2, 9, 15 in order, data held during stalls, done after row 15.
- Occupied line during DRAIN -> overrun=1 and remains; subsequent drain data unaffected; second flush after DONE drains only post-DONE rows.
- rst asserted during DRAIN with 2 rows pending -> next cycle out_valid=0, busy=0; flush -> immediate done, no words.
